// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares one single-port synchronous memory between the fetch and data ports
module soc_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;
  stateT state, nextState;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addrR;
  logic [DATA_W-1:0] wdataR;
  logic weR, grantData, lastData, pickData, start;
  // round-robin favours whichever port was not granted last
  assign pickData = d_req && (!i_req || ARB_MODE == 0 || !lastData);
  assign start = state == IDLE && (i_req || d_req);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = IDLE;
    if (start) nextState = ACCESS;
    else if (state == ACCESS) nextState = cnt == '0 ? RESP : ACCESS;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      addrR <= '0;
      wdataR <= '0;
      weR <= 1'b0;
      grantData <= 1'b0;
      lastData <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (start) begin
      grantData <= pickData;
      lastData <= pickData;
      addrR <= pickData ? d_addr : i_addr;
      weR <= pickData && d_we;
      wdataR <= pickData ? d_wdata : '0;
      cnt <= CW'(MEM_LAT - 1);
    end else if (state == ACCESS) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0 && !grantData) i_rdata <= mem_rdata;
      if (cnt == '0 && grantData && !weR) d_rdata <= mem_rdata;
    end
  assign mem_ce = state == ACCESS;
  assign mem_we = mem_ce && weR;
  assign mem_addr = mem_ce ? addrR : '0;
  assign mem_wdata = mem_ce ? wdataR : '0;
  assign i_ready = state == RESP && !grantData;
  assign d_ready = state == RESP && grantData;
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: three arbiter configurations (LAT2/fixed, LAT1/rr, LAT4/rr) against a RAM reference model
module tb_soc_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iReq [3], dReq [3], dWe [3];
  logic [31:0] iAddr [3], dAddr [3], dWdata [3];
  logic [31:0] iRdata [3], dRdata [3], memAddr [3], memWdata [3], memRdata [3];
  logic iReady [3], dReady [3], memCe [3], memWe [3];
  logic [31:0] ram [3][64];
  logic [31:0] seed [3][64];
  logic [31:0] refMem [3][64];
  bit loaded;
  int nChk = 0, nFail = 0;
  int readyCnt [3], reqCnt [3];
  int sIAt, sDAt, sCe, sWe, sIP, sDP;
  logic [31:0] expI, expD;
  bit qOrd [$];
  int qAt [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    soc_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .MEM_LAT(g == 0 ? 2 : (g == 1 ? 1 : 4)),
      .ARB_MODE(g == 0 ? 0 : 1)
    ) dut (
      .clk(clk), .rst(rst),
      .i_req(iReq[g]), .i_addr(iAddr[g]), .i_rdata(iRdata[g]), .i_ready(iReady[g]),
      .d_req(dReq[g]), .d_we(dWe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
      .d_rdata(dRdata[g]), .d_ready(dReady[g]),
      .mem_ce(memCe[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]),
      .mem_wdata(memWdata[g]), .mem_rdata(memRdata[g])
    );
    assign memRdata[g] = ram[g][memAddr[g][7:2]];
  end

  always @(posedge clk)
    if (!loaded) begin
      ram <= seed;
      loaded <= 1'b1;
    end else
      for (int k = 0; k < 3; k++)
        if (memCe[k] && memWe[k]) ram[k][memAddr[k][7:2]] <= memWdata[k];

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      readyCnt[k] <= readyCnt[k] + int'(iReady[k]) + int'(dReady[k]);

  function automatic int latOf(input int k);
    return k == 0 ? 2 : (k == 1 ? 1 : 4);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one fetch and/or one data request; each drops when its ready is seen.
  task automatic serve(input int k, input bit fi, input logic [31:0] fa, input bit di,
                       input bit we, input logic [31:0] da, input logic [31:0] wd);
    int t;
    bit iDone, dDone;
    expI = refMem[k][fa[7:2]];
    expD = refMem[k][da[7:2]];
    if (di && we) refMem[k][da[7:2]] = wd;
    @(negedge clk);
    iReq[k] = fi; iAddr[k] = fa;
    dReq[k] = di; dWe[k] = we; dAddr[k] = da; dWdata[k] = wd;
    reqCnt[k] += int'(fi) + int'(di);
    t = 0; iDone = !fi; dDone = !di;
    sIAt = 0; sDAt = 0; sCe = 0; sWe = 0; sIP = 0; sDP = 0;
    while (!(iDone && dDone) && t < 40) begin
      @(negedge clk);
      t++;
      sCe += int'(memCe[k]);
      sWe += int'(memWe[k]);
      if (iReady[k]) begin
        sIP++;
        if (!iDone) begin sIAt = t; iDone = 1; iReq[k] = 1'b0; end
      end
      if (dReady[k]) begin
        sDP++;
        if (!dDone) begin sDAt = t; dDone = 1; dReq[k] = 1'b0; end
      end
    end
    @(negedge clk);
    sIP += int'(iReady[k]);
    sDP += int'(dReady[k]);
    check("serve_complete", iDone && dDone, 1);
    iReq[k] = 1'b0; dReq[k] = 1'b0;
  endtask

  // Hold both reads high until n completions have been seen.
  task automatic holdBoth(input int k, input int n);
    int t;
    qOrd.delete(); qAt.delete();
    t = 0;
    @(negedge clk);
    iReq[k] = 1'b1; iAddr[k] = 32'h10;
    dReq[k] = 1'b1; dWe[k] = 1'b0; dAddr[k] = 32'h40;
    while (qAt.size() < n && t < 100) begin
      @(negedge clk);
      t++;
      if (iReady[k] || dReady[k]) begin
        qOrd.push_back(dReady[k]);
        qAt.push_back(t);
      end
    end
    iReq[k] = 1'b0; dReq[k] = 1'b0;
    check("hold_count", qAt.size(), n);
  endtask

  initial begin
    bit fi, di, we;
    logic [31:0] fa, da, wd;
    int pulses, rq0, rd0;
    for (int k = 0; k < 3; k++) begin
      iReq[k] = 0; dReq[k] = 0; dWe[k] = 0;
      iAddr[k] = 0; dAddr[k] = 0; dWdata[k] = 0;
      readyCnt[k] = 0; reqCnt[k] = 0;
      for (int i = 0; i < 64; i++) begin
        seed[k][i] = $urandom;
        refMem[k][i] = seed[k][i];
      end
    end
    seed[0][4] = 32'h2402000A;
    refMem[0][4] = 32'h2402000A;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_i_ready", iReady[k], 0);
      check("rst_d_ready", dReady[k], 0);
      check("rst_mem_ce", memCe[k], 0);
      check("rst_mem_we", memWe[k], 0);
      check("rst_mem_addr", memAddr[k], 0);
      check("rst_mem_wdata", memWdata[k], 0);
      check("rst_i_rdata", iRdata[k], 0);
      check("rst_d_rdata", dRdata[k], 0);
    end
    rst = 1'b0;

    serve(0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    check("fetch_latency", sIAt, 3);
    check("fetch_ce_cycles", sCe, 2);
    check("fetch_mem_we", sWe, 0);
    check("fetch_i_pulses", sIP, 1);
    check("fetch_d_pulses", sDP, 0);
    check("fetch_rdata", iRdata[0], 32'h2402000A);

    serve(0, 0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF);
    check("wr_latency", sDAt, 3);
    check("wr_we_cycles", sWe, 2);
    check("wr_d_pulses", sDP, 1);
    check("wr_keeps_rdata", dRdata[0], 0);
    serve(0, 0, 32'h0, 1, 0, 32'h40, 32'h0);
    check("rd_we_cycles", sWe, 0);
    check("rd_d_pulses", sDP, 1);
    check("rd_rdata", dRdata[0], 32'hDEADBEEF);
    serve(0, 0, 32'h0, 1, 1, 32'h44, 32'h12345678);
    check("wr2_keeps_rdata", dRdata[0], 32'hDEADBEEF);

    serve(0, 1, 32'h10, 1, 0, 32'h40, 32'h0);
    check("fixed_d_first", sDAt, latOf(0) + 1);
    check("fixed_i_after", sIAt, sDAt + latOf(0) + 2);
    check("fixed_i_width", sIP, 1);
    check("fixed_d_width", sDP, 1);
    check("fixed_i_rdata", iRdata[0], 32'h2402000A);
    check("fixed_d_rdata", dRdata[0], 32'hDEADBEEF);

    holdBoth(1, 4);
    for (int j = 0; j < qAt.size(); j++) begin
      check("rr_order", qOrd[j], (j % 2) == 0);
      check("rr_time", qAt[j], (latOf(1) + 1) + j * (latOf(1) + 2));
    end
    holdBoth(0, 3);
    for (int j = 0; j < qAt.size(); j++) begin
      check("fixed_starve_order", qOrd[j], 1);
      check("fixed_starve_time", qAt[j], (latOf(0) + 1) + j * (latOf(0) + 2));
    end

    @(negedge clk);
    dReq[0] = 1'b1; dWe[0] = 1'b1; dAddr[0] = 32'h80; dWdata[0] = 32'h5555AAAA;
    @(negedge clk);
    check("rst_mid_ce_before", memCe[0], 1);
    check("rst_mid_we_before", memWe[0], 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ce_drop", memCe[0], 0);
    check("rst_mid_we_drop", memWe[0], 0);
    check("rst_mid_addr_drop", memAddr[0], 0);
    dReq[0] = 1'b0; dWe[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(dReady[0]);
    end
    check("rst_mid_no_ready", pulses, 0);
    check("rst_mid_rdata_clr", dRdata[0], 0);
    serve(0, 0, 32'h0, 1, 1, 32'h80, 32'h5555AAAA);
    check("reissue_latency", sDAt, 3);
    check("reissue_we_cycles", sWe, 2);
    check("reissue_d_pulses", sDP, 1);
    serve(0, 0, 32'h0, 1, 0, 32'h80, 32'h0);
    check("reissue_readback", dRdata[0], 32'h5555AAAA);

    for (int k = 0; k < 3; k++) begin
      #1;
      rq0 = reqCnt[k];
      rd0 = readyCnt[k];
      repeat (30) begin
        fi = 1'($urandom_range(0, 1));
        di = 1'($urandom_range(0, 1));
        if (!fi && !di) di = 1'b1;
        we = 1'($urandom_range(0, 1));
        fa = {24'd0, 4'($urandom_range(0, 15)), 4'b0000} >> 2;
        da = {24'd0, 4'($urandom_range(0, 15)), 4'b0000} >> 2;
        if (fi && di && fa == da) fa = fa ^ 32'h4;
        wd = $urandom;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        serve(k, fi, fa, di, we, da, wd);
        check("rnd_i_pulses", sIP, fi);
        check("rnd_d_pulses", sDP, di);
        check("rnd_mem_we", sWe, (di && we) ? latOf(k) : 0);
        if (fi) check("rnd_i_rdata", iRdata[k], expI);
        if (di && !we) check("rnd_d_rdata", dRdata[k], expD);
        if (fi != di) check("rnd_latency", fi ? sIAt : sDAt, latOf(k) + 1);
      end
      #1;
      check("rnd_ready_count", readyCnt[k] - rd0, reqCnt[k] - rq0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
